// File: rtl/ahb_txn_capture.sv
// ahb_txn_capture: passive AHB-Lite tap, one record per completed transfer.
// Optional macro AHB_CAP_ALIGN_CHECK_EN adds a per-record cap_align_err.

module ahb_txn_capture #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [ADDR_W-1:0]       HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [DATA_W-1:0]       HWDATA,
  input  logic [DATA_W-1:0]       HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP,
  output logic                    cap_valid,
  input  logic                    cap_ready,
  output logic [ADDR_W-1:0]       cap_addr,
  output logic                    cap_write,
  output logic [2:0]              cap_size,
  output logic [2:0]              cap_burst,
  output logic [3:0]              cap_prot,
  output logic [DATA_W-1:0]       cap_data,
  output logic                    cap_resp,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
`ifdef AHB_CAP_ALIGN_CHECK_EN
  output logic                    cap_align_err,
`endif
  output logic [CNT_W-1:0]        drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_DATA
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
`ifdef AHB_CAP_ALIGN_CHECK_EN
    logic              align_err;
`endif
  } ctl_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic [DATA_W-1:0] data;
    logic              resp;
`ifdef AHB_CAP_ALIGN_CHECK_EN
    logic              align_err;
`endif
  } rec_t;

  state_e            state_q, state_d;
  ctl_t              ctl_q, ctl_d;
  rec_t              rec_in;
  rec_t              head;
  rec_t              mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic addr_phase;
  logic push;
  logic pop;
  logic full;
  logic wr_en;
  logic drop;
  logic align_err;

  assign addr_phase = HSEL && HREADY &&
                      (HTRANS == 2'b10 || HTRANS == 2'b11);

`ifdef AHB_CAP_ALIGN_CHECK_EN
  logic [ADDR_W-1:0] amask;
  logic              misalign;
  logic              too_wide;

  // Low address bits below the transfer size must be zero.
  always_comb begin
    amask    = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
    misalign = |(HADDR & amask);
    too_wide = (32'd8 << HSIZE) > 32'(DATA_W);
    align_err = misalign || too_wide;
  end
`else
  assign align_err = 1'b0;
`endif

  // Address/data pipeline tracker: latch control, flag completion.
  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    push    = 1'b0;
    if (state_q == S_DATA && HREADY) begin
      push    = 1'b1;
      state_d = S_IDLE;
    end
    if (addr_phase) begin
      state_d     = S_DATA;
      ctl_d.addr  = HADDR;
      ctl_d.write = HWRITE;
      ctl_d.size  = HSIZE;
      ctl_d.burst = HBURST;
      ctl_d.prot  = HPROT;
`ifdef AHB_CAP_ALIGN_CHECK_EN
      ctl_d.align_err = align_err;
`endif
    end
  end

  // Record assembled from latched control and completing-cycle data.
  always_comb begin
    rec_in       = '0;
    rec_in.addr  = ctl_q.addr;
    rec_in.write = ctl_q.write;
    rec_in.size  = ctl_q.size;
    rec_in.burst = ctl_q.burst;
    rec_in.prot  = ctl_q.prot;
    rec_in.data  = ctl_q.write ? HWDATA : HRDATA;
    rec_in.resp  = HRESP;
`ifdef AHB_CAP_ALIGN_CHECK_EN
    rec_in.align_err = ctl_q.align_err;
`endif
  end

  // FIFO bookkeeping; a full FIFO still accepts when popped same edge.
  always_comb begin
    pop   = (count_q != '0) && cap_ready;
    full  = (count_q == CW'(DEPTH));
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CW'(1);
    end

    overflow_d = overflow_q || drop;
    drop_d     = drop_q;
    if (drop && drop_q != '1) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // Tracker state registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  // FIFO pointers, occupancy and drop statistics.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Record storage; cleared so outputs read zero out of reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign cap_valid  = (count_q != '0);
  assign cap_addr   = head.addr;
  assign cap_write  = head.write;
  assign cap_size   = head.size;
  assign cap_burst  = head.burst;
  assign cap_prot   = head.prot;
  assign cap_data   = head.data;
  assign cap_resp   = head.resp;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
`ifdef AHB_CAP_ALIGN_CHECK_EN
  assign cap_align_err = head.align_err;
`else
  logic unused_align;
  assign unused_align = align_err;
`endif

endmodule

// File: tb/tb_ahb_txn_capture.sv
// tb_ahb_txn_capture: directed and random AHB transfers vs a queue model.
// Expected records come from issued transfers, not from the DUT.

module tb_ahb_txn_capture;

  localparam int DEPTH = 8;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        cap_valid;
  logic        cap_ready;
  logic [31:0] cap_addr;
  logic        cap_write;
  logic [2:0]  cap_size;
  logic [2:0]  cap_burst;
  logic [3:0]  cap_prot;
  logic [31:0] cap_data;
  logic        cap_resp;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;
`ifdef AHB_CAP_ALIGN_CHECK_EN
  logic        cap_align_err;
`endif

  always #5 HCLK = ~HCLK;

  ahb_txn_capture #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .CNT_W(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_addr(cap_addr), .cap_write(cap_write),
    .cap_size(cap_size), .cap_burst(cap_burst),
    .cap_prot(cap_prot), .cap_data(cap_data),
    .cap_resp(cap_resp), .fifo_count(fifo_count),
    .overflow(overflow),
`ifdef AHB_CAP_ALIGN_CHECK_EN
    .cap_align_err(cap_align_err),
`endif
    .drop_count(drop_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [31:0] data;
    logic        resp;
  } rec_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [31:0] data;
    int          waits;
    bit          err;
    bit          rdy_done;
  } xfer_t;

  int          tests = 0;
  int          fails = 0;
  rec_t        q[$];
  logic        m_ovf;
  logic [15:0] m_drop;
  bit          push_pending;
  rec_t        push_rec;
  bit          rand_rdy;
  xfer_t       xq[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic xfer_t mk(input logic [31:0] a, input logic w,
                               input logic [31:0] d, input int ws,
                               input logic [2:0] b);
    xfer_t t;
    t.addr = a; t.wr = w; t.data = d; t.waits = ws;
    t.burst = b; t.size = 3'd2; t.prot = 4'h3;
    t.err = 1'b0; t.rdy_done = 1'b0;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input rec_t r);
    if (q.size() < DEPTH) begin
      q.push_back(r);
    end else begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop++;
    end
  endtask

  task automatic tick();
    bit do_pop;
    if (rand_rdy) cap_ready = 1'($urandom_range(0, 1));
    @(negedge HCLK);
    chk("cap_valid", 64'(cap_valid), 64'(q.size() != 0));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    if (q.size() != 0) begin
      chk("cap_addr", 64'(cap_addr), 64'(q[0].addr));
      chk("cap_write", 64'(cap_write), 64'(q[0].wr));
      chk("cap_ctl", 64'({cap_size, cap_burst, cap_prot}),
          64'({q[0].size, q[0].burst, q[0].prot}));
      chk("cap_data", 64'(cap_data), 64'(q[0].data));
      chk("cap_resp", 64'(cap_resp), 64'(q[0].resp));
    end
    do_pop = (q.size() != 0) && cap_ready;
    @(posedge HCLK);
    if (do_pop) void'(q.pop_front());
    if (push_pending) model_push(push_rec);
    #1;
  endtask

  task automatic drive_addr(input xfer_t t, input bit seq);
    HSEL = 1'b1;
    HTRANS = seq ? 2'b11 : 2'b10;
    HADDR = t.addr; HWRITE = t.wr; HSIZE = t.size;
    HBURST = t.burst; HPROT = t.prot;
  endtask

  task automatic drive_idle();
    HSEL = 1'b1;
    HTRANS = 2'b00;
    HADDR = $urandom;
    HWRITE = 1'($urandom);
  endtask

  task automatic run();
    int   n;
    logic saved;
    n = xq.size();
    drive_addr(xq[0], 1'b0);
    HREADY = 1'b1; HRESP = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      xfer_t t;
      t = xq[i];
      if (i + 1 < n) drive_addr(xq[i+1], 1'b1);
      else drive_idle();
      HWDATA = t.wr ? t.data : $urandom;
      for (int w = 0; w < t.waits; w++) begin
        HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
        tick();
      end
      if (t.err) begin
        HREADY = 1'b0; HRESP = 1'b1; HRDATA = $urandom;
        tick();
      end
      HREADY = 1'b1; HRESP = t.err;
      HRDATA = t.wr ? $urandom : t.data;
      push_rec.addr = t.addr; push_rec.wr = t.wr;
      push_rec.size = t.size; push_rec.burst = t.burst;
      push_rec.prot = t.prot; push_rec.data = t.data;
      push_rec.resp = t.err;
      push_pending = 1'b1;
      saved = cap_ready;
      if (t.rdy_done) cap_ready = 1'b1;
      tick();
      push_pending = 1'b0;
      cap_ready = saved;
    end
    drive_idle();
    HRESP = 1'b0;
    HWDATA = $urandom;
    xq.delete();
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = '0; HBURST = '0; HPROT = '0;
    HWDATA = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    cap_ready = 1'b1; rand_rdy = 1'b0; push_pending = 1'b0;
    m_ovf = 1'b0; m_drop = '0;
    repeat (2) @(posedge HCLK);
    #1;
    tick();
    HRESETn = 1'b1;
    tick();

    // single write
    xq.push_back(mk(32'h100, 1'b1, 32'hDEADBEEF, 0, 3'b000));
    run();
    chk("wr_valid", 64'(cap_valid), 64'd1);
    chk("wr_addr", 64'(cap_addr), 64'h100);
    chk("wr_data", 64'(cap_data), 64'hDEADBEEF);
    repeat (3) tick();

    // INCR4 reads, two waits on beat 2
    for (int i = 0; i < 4; i++) begin
      xq.push_back(mk(32'h200 + 32'(4*i), 1'b0,
                      32'hA000_0000 + 32'(i), (i == 1) ? 2 : 0, 3'b011));
    end
    run();
    repeat (3) tick();

    // two-cycle ERROR response, then IDLE
    xq.push_back(mk(32'h300, 1'b1, 32'h1234_5678, 0, 3'b000));
    xq[0].err = 1'b1;
    run();
    chk("err_resp", 64'(cap_resp), 64'd1);
    chk("err_addr", 64'(cap_addr), 64'h300);
    repeat (3) tick();

    // overflow: ten transfers into eight entries
    cap_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      xq.push_back(mk(32'h1000 + 32'(4*i), 1'($urandom), $urandom,
                      0, 3'b001));
    end
    run();
    chk("ovf_count", 64'(fifo_count), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd2);
    chk("ovf_head", 64'(cap_addr), 64'h1000);
    tick();
    cap_ready = 1'b1;
    repeat (10) tick();

    // full FIFO, pop on the completing edge
    cap_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xq.push_back(mk(32'h2000 + 32'(4*i), 1'b1, $urandom, 0, 3'b001));
    end
    run();
    xq.push_back(mk(32'h2100, 1'b0, 32'hCAFE_F00D, 1, 3'b000));
    xq[0].rdy_done = 1'b1;
    run();
    chk("fullpop_count", 64'(fifo_count), 64'd8);
    chk("fullpop_drops", 64'(drop_count), 64'd2);
    tick();
    cap_ready = 1'b1;
    repeat (10) tick();

    // randomized bursts with random consumer backpressure
    rand_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int          len;
      logic [31:0] base;
      logic [2:0]  sz;
      len = $urandom_range(1, 4);
      base = $urandom & 32'hFFFF_FF00;
      sz = 3'($urandom_range(0, 2));
      for (int i = 0; i < len; i++) begin
        xfer_t t;
        t = mk(base + (32'(i) << sz), 1'($urandom), $urandom,
               $urandom_range(0, 2), (len == 4) ? 3'b011 : 3'b001);
        t.size = sz;
        t.prot = 4'($urandom);
        t.err = (i == len - 1) && ($urandom_range(0, 7) == 0);
        xq.push_back(t);
      end
      run();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        case ($urandom_range(0, 2))
          0: drive_idle();
          1: begin HSEL = 1'b1; HTRANS = 2'b01; HADDR = $urandom; end
          default: begin
            HSEL = 1'b0; HTRANS = 2'b10; HADDR = $urandom;
          end
        endcase
        HREADY = 1'b1;
        tick();
      end
      drive_idle();
    end
    rand_rdy = 1'b0;
    cap_ready = 1'b1;
    repeat (DEPTH + 2) tick();

    // reset mid data phase with three records queued
    cap_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xq.push_back(mk(32'h3000 + 32'(4*i), 1'b1, $urandom, 0, 3'b001));
    end
    run();
    if (!m_ovf) begin
      m_ovf = 1'b0;
    end
    drive_addr(mk(32'h400, 1'b1, 32'h0, 0, 3'b000), 1'b0);
    HREADY = 1'b1;
    tick();
    drive_idle();
    HREADY = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_valid", 64'(cap_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    q.delete();
    m_ovf = 1'b0;
    m_drop = '0;
    @(posedge HCLK);
    #1;
    HREADY = 1'b1;
    HRESETn = 1'b1;
    cap_ready = 1'b1;
    repeat (3) tick();
    xq.push_back(mk(32'h500, 1'b0, 32'h5555_AAAA, 0, 3'b000));
    run();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_txn_capture.md
Name: ahb_txn_capture

Overview:
Parameterised passive AHB-Lite bus tap, replacing the flat signal-mirroring wrapper. It tracks the AHB address/data pipeline and assembles one record per completed transfer. Records go into a FIFO drained by the verification scoreboard over a valid/ready handshake. It drives nothing onto the bus and sits beside the slave on the bus interface.

Parameters:
ADDR_W, 32, HADDR width
DATA_W, 32, HWDATA/HRDATA width (32/64/128)
DEPTH, 8, capture FIFO entries (power of 2, >=2)
CNT_W, 16, width of drop counter

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  ADDR_W  address
HTRANS  in  2  transfer type
HWRITE  in  1  write=1
HSIZE  in  3  transfer size
HBURST  in  3  burst type
HPROT  in  4  protection
HWDATA  in  DATA_W  write data
HRDATA  in  DATA_W  read data
HREADY  in  1  bus ready
HRESP  in  1  response
cap_valid  out  1  record available
cap_ready  in  1  consumer accepts record
cap_addr  out  ADDR_W  record address
cap_write/cap_size/cap_burst/cap_prot  out  1/3/3/4  record control
cap_data  out  DATA_W  HWDATA (write) or HRDATA (read)
cap_resp  out  1  1=ERROR
fifo_count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: a record was dropped
drop_count  out  CNT_W  dropped records, saturating

Behaviour:
- Clock HCLK; reset HRESETn asynchronous, active-low. Reset: all outputs 0, FIFO empty, FSM IDLE, pending record discarded (also mid-transfer).
- Valid address phase: rising edge with HSEL=1, HREADY=1, HTRANS in {NONSEQ=2, SEQ=3}. IDLE/BUSY never captured.
- FSM IDLE: valid address phase -> latch HADDR/HWRITE/HSIZE/HBURST/HPROT, go DATA.
- FSM DATA: HREADY=0 -> hold (wait states, any count). HREADY=1 -> complete: data = HWRITE ? HWDATA : HRDATA, resp = HRESP; push. Same edge also valid address phase -> latch new control, stay DATA; else -> IDLE.
- ERROR: resp taken at completing edge (second ERROR cycle, HRESP=1, HREADY=1); cap_resp=1.
- Latency: record visible on cap_valid/cap_* the cycle after completing edge.
- Pop when cap_valid & cap_ready; cap_* shows FIFO head, stable while cap_valid & !cap_ready.
- Full + push + pop same edge: both occur, no drop, count unchanged.
- Full + push, no pop: record dropped, overflow<=1 (sticky until reset), drop_count+1, saturates at all-ones.
- Empty + pop attempt: ignored. Pointers wrap modulo DEPTH.

Optional Feature:
Macro AHB_CAP_ALIGN_CHECK_EN. Defined: extra output cap_align_err (1 bit) stored per record; set when HADDR not aligned to 2^HSIZE or 2^HSIZE*8 > DATA_W. Undefined: port and logic absent; records otherwise identical.

Test Plan:
- Single NONSEQ write, HADDR=0x100, HWDATA=0xDEADBEEF, no waits, cap_ready=1 -> one record cap_addr=0x100, cap_write=1, cap_data=0xDEADBEEF, cap_resp=0, valid 1 cycle after data phase.
- Back-to-back INCR4 reads from 0x200, 2 wait states on beat 2 -> 4 records 0x200/0x204/0x208/0x20C with matching HRDATA, in order, none during waits.
- Two-cycle ERROR response on write to 0x300 -> record cap_resp=1; following IDLE not captured.
- DEPTH=8, cap_ready=0, 10 transfers -> fifo_count=8, overflow=1, drop_count=2; drain gives first 8 records.
- Full FIFO, cap_ready=1 on completing edge -> no drop, fifo_count stays 8.
- HRESETn low mid data phase with 3 records queued -> cap_valid=0, fifo_count=0, overflow=0 immediately; no stale record after release.
